// File: rtl/multi_alarm_timekeeper_pkg.sv
// Shared definitions for the alarm-clock timekeeper: FSM state codes, BCD time
// layout, digit limits and the BCD validity/increment helpers.
package multi_alarm_timekeeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RINGING = 2'b01,
    ST_SNOOZE  = 2'b10
  } alarm_state_e;

  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } bcd_time_t;

  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

  function automatic logic bcd_time_valid(input bcd_time_t t);
    return (t.m10 <= BCD_MAX_TENS) && (t.m1 <= BCD_MAX_UNITS) &&
           (t.s10 <= BCD_MAX_TENS) && (t.s1 <= BCD_MAX_UNITS);
  endfunction

  // Ripple-carry one second through MM:SS; 59:59 rolls over to 00:00.
  function automatic bcd_time_t bcd_time_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s1 != BCD_MAX_UNITS) begin
      r.s1 = t.s1 + 4'd1;
    end else begin
      r.s1 = 4'd0;
      if (t.s10 != BCD_MAX_TENS) begin
        r.s10 = t.s10 + 4'd1;
      end else begin
        r.s10 = 4'd0;
        if (t.m1 != BCD_MAX_UNITS) begin
          r.m1 = t.m1 + 4'd1;
        end else begin
          r.m1  = 4'd0;
          r.m10 = (t.m10 != BCD_MAX_TENS) ? (t.m10 + 4'd1) : 4'd0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_alarm_timekeeper_bcd_mmss_counter.sv
// One-second prescaler and BCD MM:SS counter. A load replaces the time, restarts
// the prescaler and suppresses the tick of that cycle.
module bcd_mmss_counter
  import multi_alarm_timekeeper_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load_i,
  input  bcd_time_t load_time_i,
  output bcd_time_t time_o,
  output bcd_time_t time_inc_o,
  output logic      tick_o
);

  localparam int unsigned   PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  bcd_time_t     time_q, time_d;
  logic          wrap;

  always_comb begin
    wrap       = (pre_q == PRE_LAST);
    tick_o     = wrap && !load_i;
    time_inc_o = bcd_time_inc(time_q);
    pre_d      = wrap ? '0 : (pre_q + PW'(1));
    time_d     = time_q;
    if (load_i) begin
      pre_d  = '0;
      time_d = load_time_i;
    end else if (wrap) begin
      time_d = time_inc_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      time_q <= '0;
    end else begin
      pre_q  <= pre_d;
      time_q <= time_d;
    end
  end

  assign time_o = time_q;

endmodule

// File: rtl/multi_alarm_timekeeper.sv
// Timekeeping core: BCD clock, programmable alarm table with lowest-index
// priority, and the ring/snooze/timeout state machine.
module multi_alarm_timekeeper
  import multi_alarm_timekeeper_pkg::*;
#(
  parameter  int unsigned TICK_DIV     = 100_000_000,
  parameter  int unsigned NUM_ALARMS   = 4,
  parameter  int unsigned SNOOZE_SEC   = 300,
  parameter  int unsigned RING_TMO_SEC = 60,
  parameter  int unsigned MAX_SNOOZE   = 3,
  localparam int unsigned IDX_W        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_time_valid_i,
  input  logic [15:0]           set_time_i,
  input  logic                  alarm_wr_en_i,
  input  logic [IDX_W-1:0]      alarm_wr_idx_i,
  input  logic [15:0]           alarm_wr_time_i,
  input  logic                  alarm_wr_enable_i,
  input  logic                  snooze_i,
  input  logic                  dismiss_i,
  output logic [15:0]           current_time_o,
  output logic                  tick_o,
  output logic                  ring_o,
  output logic [IDX_W-1:0]      ring_idx_o,
  output logic [1:0]            alarm_state_o,
  output logic [NUM_ALARMS-1:0] missed_o,
  output logic                  set_err_o
);

  localparam int unsigned SC_W      = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam logic [15:0] RING_LOAD = 16'(RING_TMO_SEC);
  localparam logic [15:0] SNZ_LOAD  = 16'(SNOOZE_SEC);

  bcd_time_t             cur_time, inc_time;
  logic                  tick;
  logic                  set_ok, wr_ok, set_err_d, set_err_q;
  bcd_time_t             alarm_time_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] alarm_en_q;
  logic                  match_hit;
  logic [IDX_W-1:0]      match_idx;

  alarm_state_e          state_q, state_d;
  logic [IDX_W-1:0]      ring_idx_q, ring_idx_d;
  logic [SC_W-1:0]       snz_cnt_q, snz_cnt_d;
  logic [15:0]           timer_q, timer_d;
  logic [NUM_ALARMS-1:0] missed_q, missed_d;

  assign set_ok    = set_time_valid_i && bcd_time_valid(bcd_time_t'(set_time_i));
  assign wr_ok     = alarm_wr_en_i && bcd_time_valid(bcd_time_t'(alarm_wr_time_i)) &&
                     (32'(alarm_wr_idx_i) < NUM_ALARMS);
  assign set_err_d = (set_time_valid_i && !bcd_time_valid(bcd_time_t'(set_time_i))) ||
                     (alarm_wr_en_i && !bcd_time_valid(bcd_time_t'(alarm_wr_time_i)));

  bcd_mmss_counter #(
    .TICK_DIV(TICK_DIV)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (set_ok),
    .load_time_i(bcd_time_t'(set_time_i)),
    .time_o     (cur_time),
    .time_inc_o (inc_time),
    .tick_o     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alarm_time_q[i] <= '0;
      end
      alarm_en_q <= '0;
    end else if (wr_ok) begin
      alarm_time_q[alarm_wr_idx_i] <= bcd_time_t'(alarm_wr_time_i);
      alarm_en_q[alarm_wr_idx_i]   <= alarm_wr_enable_i;
    end
  end

  // Scan downwards so the lowest matching channel is the one left standing.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alarm_en_q[i] && (alarm_time_q[i] == inc_time)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ring_idx_d = ring_idx_q;
    snz_cnt_d  = snz_cnt_q;
    timer_d    = timer_q;
    missed_d   = missed_q;
    if (wr_ok) begin
      missed_d[alarm_wr_idx_i] = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (tick && match_hit) begin
          state_d    = ST_RINGING;
          ring_idx_d = match_idx;
          snz_cnt_d  = '0;
          timer_d    = RING_LOAD;
        end
      end
      ST_RINGING: begin
        if (dismiss_i) begin
          state_d = ST_IDLE;
        end else if (snooze_i && (snz_cnt_q < SC_W'(MAX_SNOOZE))) begin
          state_d   = ST_SNOOZE;
          snz_cnt_d = snz_cnt_q + SC_W'(1);
          timer_d   = SNZ_LOAD;
        end else if (tick) begin
          if (timer_q <= 16'd1) begin
            state_d              = ST_IDLE;
            timer_d              = '0;
            missed_d[ring_idx_q] = 1'b1;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
      end
      ST_SNOOZE: begin
        if (dismiss_i) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (timer_q <= 16'd1) begin
            state_d = ST_RINGING;
            timer_d = RING_LOAD;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Disabling the channel that is currently ringing or snoozing ends the event.
    if ((state_q != ST_IDLE) && wr_ok && !alarm_wr_enable_i && (alarm_wr_idx_i == ring_idx_q)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ring_idx_q <= '0;
      snz_cnt_q  <= '0;
      timer_q    <= '0;
      missed_q   <= '0;
      set_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_idx_q <= ring_idx_d;
      snz_cnt_q  <= snz_cnt_d;
      timer_q    <= timer_d;
      missed_q   <= missed_d;
      set_err_q  <= set_err_d;
    end
  end

  assign current_time_o = cur_time;
  assign tick_o         = tick;
  assign ring_o         = (state_q == ST_RINGING);
  assign ring_idx_o     = ring_idx_q;
  assign alarm_state_o  = state_q;
  assign missed_o       = missed_q;
  assign set_err_o      = set_err_q;

endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// Directed bench for multi_alarm_timekeeper with a 4-cycle second so whole
// ring/snooze/timeout sequences fit in a few hundred cycles.
module tb_multi_alarm_timekeeper;

  localparam int OP_SET     = 0;
  localparam int OP_WR      = 1;
  localparam int OP_SNOOZE  = 2;
  localparam int OP_DISMISS = 3;
  localparam int OP_BOTH    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set_time_valid_i = 1'b0;
  logic [15:0] set_time_i = '0;
  logic        alarm_wr_en_i = 1'b0;
  logic [1:0]  alarm_wr_idx_i = '0;
  logic [15:0] alarm_wr_time_i = '0;
  logic        alarm_wr_enable_i = 1'b0;
  logic        snooze_i = 1'b0;
  logic        dismiss_i = 1'b0;
  logic [15:0] current_time_o;
  logic        tick_o;
  logic        ring_o;
  logic [1:0]  ring_idx_o;
  logic [1:0]  alarm_state_o;
  logic [3:0]  missed_o;
  logic        set_err_o;

  int numChecks = 0;
  int numFailures = 0;
  int tickCycles;

  always #5 clk = ~clk;

  multi_alarm_timekeeper #(
    .TICK_DIV    (4),
    .NUM_ALARMS  (4),
    .SNOOZE_SEC  (3),
    .RING_TMO_SEC(5),
    .MAX_SNOOZE  (1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .set_time_valid_i (set_time_valid_i),
    .set_time_i       (set_time_i),
    .alarm_wr_en_i    (alarm_wr_en_i),
    .alarm_wr_idx_i   (alarm_wr_idx_i),
    .alarm_wr_time_i  (alarm_wr_time_i),
    .alarm_wr_enable_i(alarm_wr_enable_i),
    .snooze_i         (snooze_i),
    .dismiss_i        (dismiss_i),
    .current_time_o   (current_time_o),
    .tick_o           (tick_o),
    .ring_o           (ring_o),
    .ring_idx_o       (ring_idx_o),
    .alarm_state_o    (alarm_state_o),
    .missed_o         (missed_o),
    .set_err_o        (set_err_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFailures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one request for a single cycle, starting on a falling edge; returns on
  // the falling edge after the capturing clock so registered results are visible.
  task automatic applyStimulus(input int op, input logic [15:0] t, input logic [1:0] idx, input logic en);
    case (op)
      OP_SET: begin
        set_time_i       = t;
        set_time_valid_i = 1'b1;
      end
      OP_WR: begin
        alarm_wr_time_i   = t;
        alarm_wr_idx_i    = idx;
        alarm_wr_enable_i = en;
        alarm_wr_en_i     = 1'b1;
      end
      OP_SNOOZE:  snooze_i = 1'b1;
      OP_DISMISS: dismiss_i = 1'b1;
      OP_BOTH: begin
        snooze_i  = 1'b1;
        dismiss_i = 1'b1;
      end
      default: ;
    endcase
    @(negedge clk);
    set_time_valid_i = 1'b0;
    alarm_wr_en_i    = 1'b0;
    snooze_i         = 1'b0;
    dismiss_i        = 1'b0;
  endtask

  // Wait (bounded) for a tick, then step past the edge that consumes it.
  task automatic waitTick(output int cyc);
    cyc = 0;
    while (!tick_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("tick_seen", 32'(tick_o), 32'd1);
    @(negedge clk);
  endtask

  task automatic ringAtFive(input logic [1:0] expIdx);
    applyStimulus(OP_SET, 16'h0003, 2'd0, 1'b0);
    waitTick(tickCycles);
    checkOutput("pre_ring_quiet", 32'(ring_o), 32'd0);
    waitTick(tickCycles);
    checkOutput("ring_time", 32'(current_time_o), 32'h0005);
    checkOutput("ring_on", 32'(ring_o), 32'd1);
    checkOutput("ring_idx", 32'(ring_idx_o), 32'(expIdx));
    checkOutput("ring_state", 32'(alarm_state_o), 32'd1);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_time", 32'(current_time_o), 32'h0000);
    checkOutput("rst_state", 32'(alarm_state_o), 32'd0);
    checkOutput("rst_ring", 32'(ring_o), 32'd0);
    checkOutput("rst_idx", 32'(ring_idx_o), 32'd0);
    checkOutput("rst_missed", 32'(missed_o), 32'd0);
    checkOutput("rst_set_err", 32'(set_err_o), 32'd0);
    checkOutput("rst_tick", 32'(tick_o), 32'd0);
    rst_n = 1'b1;

    $display("[TB] time load and rollover");
    applyStimulus(OP_SET, 16'h5958, 2'd0, 1'b0);
    checkOutput("load_time", 32'(current_time_o), 32'h5958);
    checkOutput("load_no_err", 32'(set_err_o), 32'd0);
    waitTick(tickCycles);
    checkOutput("tick1_time", 32'(current_time_o), 32'h5959);
    checkOutput("tick1_period", 32'(tickCycles + 1), 32'd4);
    waitTick(tickCycles);
    checkOutput("wrap_time", 32'(current_time_o), 32'h0000);
    checkOutput("tick2_period", 32'(tickCycles + 1), 32'd4);
    for (int i = 0; i < 6; i++) begin
      waitTick(tickCycles);
      checkOutput("run_period", 32'(tickCycles + 1), 32'd4);
    end
    checkOutput("run8_time", 32'(current_time_o), 32'h0006);

    $display("[TB] invalid BCD rejection");
    applyStimulus(OP_SET, 16'h0A00, 2'd0, 1'b0);
    checkOutput("bad_set_err", 32'(set_err_o), 32'd1);
    checkOutput("bad_set_time", 32'(current_time_o), 32'h0006);
    applyStimulus(OP_WR, 16'h0099, 2'd0, 1'b1);
    checkOutput("bad_wr_err", 32'(set_err_o), 32'd1);
    @(negedge clk);
    checkOutput("err_pulse_end", 32'(set_err_o), 32'd0);

    $display("[TB] alarm match and priority");
    applyStimulus(OP_WR, 16'h0005, 2'd1, 1'b1);
    checkOutput("good_wr_no_err", 32'(set_err_o), 32'd0);
    applyStimulus(OP_WR, 16'h0005, 2'd3, 1'b1);
    ringAtFive(2'd1);

    $display("[TB] snooze sequence");
    applyStimulus(OP_SNOOZE, 16'h0000, 2'd0, 1'b0);
    checkOutput("snz_state", 32'(alarm_state_o), 32'd2);
    checkOutput("snz_ring_off", 32'(ring_o), 32'd0);
    waitTick(tickCycles);
    checkOutput("snz_t1", 32'(alarm_state_o), 32'd2);
    waitTick(tickCycles);
    checkOutput("snz_t2", 32'(alarm_state_o), 32'd2);
    waitTick(tickCycles);
    checkOutput("snz_t3_ring", 32'(alarm_state_o), 32'd1);
    checkOutput("snz_t3_idx", 32'(ring_idx_o), 32'd1);
    applyStimulus(OP_SNOOZE, 16'h0000, 2'd0, 1'b0);
    checkOutput("snz_limit", 32'(alarm_state_o), 32'd1);
    applyStimulus(OP_DISMISS, 16'h0000, 2'd0, 1'b0);
    checkOutput("dismiss_state", 32'(alarm_state_o), 32'd0);
    checkOutput("dismiss_ring", 32'(ring_o), 32'd0);
    checkOutput("dismiss_missed", 32'(missed_o), 32'd0);

    $display("[TB] unattended timeout");
    ringAtFive(2'd1);
    for (int k = 1; k <= 4; k++) begin
      waitTick(tickCycles);
      checkOutput("tmo_still_ring", 32'(alarm_state_o), 32'd1);
    end
    waitTick(tickCycles);
    checkOutput("tmo_state", 32'(alarm_state_o), 32'd0);
    checkOutput("tmo_missed", 32'(missed_o), 32'b0010);
    applyStimulus(OP_WR, 16'h0005, 2'd1, 1'b1);
    checkOutput("missed_clear", 32'(missed_o), 32'd0);

    $display("[TB] disable active channel");
    ringAtFive(2'd1);
    applyStimulus(OP_WR, 16'h0005, 2'd1, 1'b0);
    checkOutput("disable_state", 32'(alarm_state_o), 32'd0);
    checkOutput("disable_ring", 32'(ring_o), 32'd0);

    $display("[TB] snooze and dismiss together");
    ringAtFive(2'd3);
    applyStimulus(OP_BOTH, 16'h0000, 2'd0, 1'b0);
    checkOutput("both_state", 32'(alarm_state_o), 32'd0);

    $display("[TB] reset during snooze");
    ringAtFive(2'd3);
    applyStimulus(OP_SNOOZE, 16'h0000, 2'd0, 1'b0);
    checkOutput("pre_rst_snz", 32'(alarm_state_o), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_time", 32'(current_time_o), 32'h0000);
    checkOutput("arst_state", 32'(alarm_state_o), 32'd0);
    checkOutput("arst_idx", 32'(ring_idx_o), 32'd0);
    checkOutput("arst_ring", 32'(ring_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_SET, 16'h0003, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      waitTick(tickCycles);
    end
    checkOutput("post_rst_time", 32'(current_time_o), 32'h0006);
    checkOutput("post_rst_no_ring", 32'(alarm_state_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFailures);
    $finish;
  end

endmodule
